// File: rtl/control_unit_if.sv
// Bus between the control unit and its datapath/memories: instruction fetch,
// data-memory strobes, register-file controls and the zero flag.
interface control_unit_if #(
  parameter int PC_WIDTH = 16,
  parameter int REGBITS  = 4,
  parameter int DADDR    = 8
);
  logic [PC_WIDTH-1:0] i_addr;
  logic                i_rd;
  logic [15:0]         i_data;
  logic [DADDR-1:0]    d_addr;
  logic                d_rd;
  logic                d_wr;
  logic [7:0]          rf_w_data;
  logic [REGBITS-1:0]  rf_w_addr;
  logic                rf_w_wr;
  logic [REGBITS-1:0]  rf_rp_addr;
  logic                rf_rp_rd;
  logic [REGBITS-1:0]  rf_rq_addr;
  logic                rf_rq_rd;
  logic [1:0]          rf_s;
  logic [1:0]          alu_s;
  logic                rf_rp_zero;
  logic                halted;

  modport master (
    output i_addr, i_rd, d_addr, d_rd, d_wr, rf_w_data, rf_w_addr, rf_w_wr,
           rf_rp_addr, rf_rp_rd, rf_rq_addr, rf_rq_rd, rf_s, alu_s, halted,
    input  i_data, rf_rp_zero
  );

  modport slave (
    input  i_addr, i_rd, d_addr, d_rd, d_wr, rf_w_data, rf_w_addr, rf_w_wr,
           rf_rp_addr, rf_rp_rd, rf_rq_addr, rf_rq_rd, rf_s, alu_s, halted,
    output i_data, rf_rp_zero
  );
endinterface

// File: rtl/control_unit.sv
// Moore-FSM control unit for the 6-instruction processor (PC, IR, decode).
// Define HALT_EN to make opcode 1111 enter a sticky HALT state.
module control_unit #(
  parameter int PC_WIDTH = 16,
  parameter int REGBITS  = 4,
  parameter int DADDR    = 8
) (
  input  logic          clk,
  input  logic          reset,
  control_unit_if.master bus
);
  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_LOAD, S_STORE, S_ADD, S_SUB,
    S_LOADC, S_JMPZ_TEST, S_JMPZ_TAKE, S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;

  logic [3:0]          op;
  logic [REGBITS-1:0]  ra, rb, rc;
  logic [DADDR-1:0]    dfield;
  logic [PC_WIDTH-1:0] off_sext;

  assign op       = ir_q[15:12];
  assign ra       = REGBITS'(ir_q[11:8]);
  assign rb       = REGBITS'(ir_q[7:4]);
  assign rc       = REGBITS'(ir_q[3:0]);
  assign dfield   = DADDR'(ir_q[7:0]);
  assign off_sext = {{(PC_WIDTH-8){ir_q[7]}}, ir_q[7:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    bus.i_addr     = pc_q;
    bus.i_rd       = 1'b0;
    bus.d_addr     = '0;
    bus.d_rd       = 1'b0;
    bus.d_wr       = 1'b0;
    bus.rf_w_data  = '0;
    bus.rf_w_addr  = '0;
    bus.rf_w_wr    = 1'b0;
    bus.rf_rp_addr = '0;
    bus.rf_rp_rd   = 1'b0;
    bus.rf_rq_addr = '0;
    bus.rf_rq_rd   = 1'b0;
    bus.rf_s       = 2'b00;
    bus.alu_s      = 2'b00;
    bus.halted     = 1'b0;

    case (state_q)
      S_INIT: begin
        pc_d    = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.i_rd = 1'b1;
        ir_d     = bus.i_data;
        pc_d     = pc_q + 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          4'b0000: state_d = S_LOAD;
          4'b0001: state_d = S_STORE;
          4'b0010: state_d = S_ADD;
          4'b0011: state_d = S_LOADC;
          4'b0100: state_d = S_SUB;
          4'b0101: state_d = S_JMPZ_TEST;
`ifdef HALT_EN
          4'b1111: state_d = S_HALT;
`endif
          default: state_d = S_FETCH;
        endcase
      end
      S_LOAD: begin
        bus.d_addr    = dfield;
        bus.d_rd      = 1'b1;
        bus.rf_s      = 2'b01;
        bus.rf_w_addr = ra;
        bus.rf_w_wr   = 1'b1;
        state_d       = S_FETCH;
      end
      S_STORE: begin
        bus.d_addr     = dfield;
        bus.d_wr       = 1'b1;
        bus.rf_rp_addr = ra;
        bus.rf_rp_rd   = 1'b1;
        state_d        = S_FETCH;
      end
      S_ADD, S_SUB: begin
        bus.rf_rp_addr = rb;
        bus.rf_rp_rd   = 1'b1;
        bus.rf_rq_addr = rc;
        bus.rf_rq_rd   = 1'b1;
        bus.alu_s      = (state_q == S_ADD) ? 2'b01 : 2'b10;
        bus.rf_s       = 2'b00;
        bus.rf_w_addr  = ra;
        bus.rf_w_wr    = 1'b1;
        state_d        = S_FETCH;
      end
      S_LOADC: begin
        bus.rf_w_data = ir_q[7:0];
        bus.rf_s      = 2'b10;
        bus.rf_w_addr = ra;
        bus.rf_w_wr   = 1'b1;
        state_d       = S_FETCH;
      end
      S_JMPZ_TEST: begin
        bus.rf_rp_addr = ra;
        bus.rf_rp_rd   = 1'b1;
        state_d        = bus.rf_rp_zero ? S_JMPZ_TAKE : S_FETCH;
      end
      S_JMPZ_TAKE: begin
        // PC already points past the JMPZ, hence the -1 to make offsets relative to it.
        pc_d    = pc_q + off_sext - 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
`ifdef HALT_EN
        bus.halted = 1'b1;
`endif
        state_d = S_HALT;
      end
      default: state_d = S_INIT;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; define HALT_EN to build the
// halt-enabled variant and its expectations.
module tb_control_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [15:0] imem [65536];

  always #5 clk = ~clk;

  control_unit_if #(.PC_WIDTH(16), .REGBITS(4), .DADDR(8)) bus ();

  control_unit #(.PC_WIDTH(16), .REGBITS(4), .DADDR(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.i_data = imem[bus.i_addr];

  function automatic logic [54:0] all_out();
    return {bus.i_addr, bus.d_addr, bus.rf_w_data, bus.rf_w_addr, bus.rf_rp_addr,
            bus.rf_rq_addr, bus.rf_s, bus.alu_s, bus.i_rd, bus.d_rd, bus.d_wr,
            bus.rf_w_wr, bus.rf_rp_rd, bus.rf_rq_rd, bus.halted};
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 65536; i++) imem[i] = 16'h7000;
  endtask

  // Leaves the DUT in INIT, sampled mid-cycle.
  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic wait_fetch(input logic [15:0] addr, input int budget,
                            output bit found, output int cycles);
    found  = 1'b0;
    cycles = 0;
    while (!found && cycles < budget) begin
      if (bus.i_rd === 1'b1 && bus.i_addr === addr) found = 1'b1;
      else begin
        step();
        cycles++;
      end
    end
  endtask

  task automatic test_reset();
    fill_nop();
    imem[0] = 16'h2312;
    do_reset();
    n_cmp++;
    if (all_out() !== 55'd0) begin
      n_fail++; $display("FAIL init_outputs: got %h want 0", all_out());
    end
    step();
    n_cmp++;
    if (bus.i_rd !== 1'b1 || bus.i_addr !== 16'h0000) begin
      n_fail++; $display("FAIL first_fetch: i_rd=%b i_addr=%h want 1/0000", bus.i_rd, bus.i_addr);
    end
    step(2);
    n_cmp++;
    if (bus.rf_w_wr !== 1'b1 || bus.alu_s !== 2'b01 || bus.rf_w_addr !== 4'd3 ||
        bus.rf_rp_addr !== 4'd1 || bus.rf_rq_addr !== 4'd2) begin
      n_fail++; $display("FAIL add_cycle: wr=%b alu=%b wa=%h rp=%h rq=%h want 1/01/3/1/2",
                         bus.rf_w_wr, bus.alu_s, bus.rf_w_addr, bus.rf_rp_addr, bus.rf_rq_addr);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (all_out() !== 55'd0) begin
      n_fail++; $display("FAIL reset_mid_add: got %h want 0", all_out());
    end
    step();
    reset = 1'b0;
    n_cmp++;
    if (all_out() !== 55'd0) begin
      n_fail++; $display("FAIL post_reset_init: got %h want 0", all_out());
    end
    step();
    n_cmp++;
    if (bus.i_rd !== 1'b1 || bus.i_addr !== 16'h0000) begin
      n_fail++; $display("FAIL restart_fetch: i_rd=%b i_addr=%h want 1/0000", bus.i_rd, bus.i_addr);
    end
    $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_fail);
  endtask

  task automatic test_loadc_sub();
    fill_nop();
    imem[0] = 16'h3105;
    imem[1] = 16'h3203;
    imem[2] = 16'h4312;
    do_reset();
    step(3);
    n_cmp++;
    if (bus.rf_w_data !== 8'h05 || bus.rf_s !== 2'b10 || bus.rf_w_addr !== 4'd1 || bus.rf_w_wr !== 1'b1) begin
      n_fail++; $display("FAIL loadc1: data=%h s=%b wa=%h wr=%b want 05/10/1/1",
                         bus.rf_w_data, bus.rf_s, bus.rf_w_addr, bus.rf_w_wr);
    end
    step(3);
    n_cmp++;
    if (bus.rf_w_data !== 8'h03 || bus.rf_s !== 2'b10 || bus.rf_w_addr !== 4'd2 || bus.rf_w_wr !== 1'b1) begin
      n_fail++; $display("FAIL loadc2: data=%h s=%b wa=%h wr=%b want 03/10/2/1",
                         bus.rf_w_data, bus.rf_s, bus.rf_w_addr, bus.rf_w_wr);
    end
    step(3);
    n_cmp++;
    if (bus.rf_rp_addr !== 4'd1 || bus.rf_rq_addr !== 4'd2 || bus.alu_s !== 2'b10 ||
        bus.rf_w_addr !== 4'd3 || bus.rf_w_wr !== 1'b1 || bus.rf_s !== 2'b00 ||
        bus.rf_rp_rd !== 1'b1 || bus.rf_rq_rd !== 1'b1) begin
      n_fail++; $display("FAIL sub_cycle: rp=%h rq=%h alu=%b wa=%h wr=%b s=%b want 1/2/10/3/1/00",
                         bus.rf_rp_addr, bus.rf_rq_addr, bus.alu_s, bus.rf_w_addr, bus.rf_w_wr, bus.rf_s);
    end
    step();
    n_cmp++;
    if (bus.i_addr !== 16'h0003 || bus.i_rd !== 1'b1) begin
      n_fail++; $display("FAIL fetch_after_9: i_addr=%h i_rd=%b want 0003/1", bus.i_addr, bus.i_rd);
    end
    $display("test_loadc_sub done: compared=%0d mismatched=%0d", n_cmp, n_fail);
  endtask

  task automatic test_load_store();
    fill_nop();
    imem[0] = 16'h0420;
    imem[1] = 16'h1421;
    do_reset();
    step(3);
    n_cmp++;
    if (bus.d_addr !== 8'h20 || bus.d_rd !== 1'b1 || bus.d_wr !== 1'b0 || bus.rf_s !== 2'b01 ||
        bus.rf_w_addr !== 4'd4 || bus.rf_w_wr !== 1'b1) begin
      n_fail++; $display("FAIL load_cycle: da=%h rd=%b wr=%b s=%b wa=%h wwr=%b want 20/1/0/01/4/1",
                         bus.d_addr, bus.d_rd, bus.d_wr, bus.rf_s, bus.rf_w_addr, bus.rf_w_wr);
    end
    step(3);
    n_cmp++;
    if (bus.d_addr !== 8'h21 || bus.d_wr !== 1'b1 || bus.d_rd !== 1'b0 || bus.rf_rp_addr !== 4'd4 ||
        bus.rf_rp_rd !== 1'b1 || bus.rf_w_wr !== 1'b0) begin
      n_fail++; $display("FAIL store_cycle: da=%h wr=%b rd=%b rp=%h rprd=%b wwr=%b want 21/1/0/4/1/0",
                         bus.d_addr, bus.d_wr, bus.d_rd, bus.rf_rp_addr, bus.rf_rp_rd, bus.rf_w_wr);
    end
    $display("test_load_store done: compared=%0d mismatched=%0d", n_cmp, n_fail);
  endtask

  task automatic run_jmpz(input logic [7:0] off, input logic zero,
                          input logic [15:0] exp_pc, input int exp_lat, input string name);
    bit found;
    int cycles;
    fill_nop();
    imem[10] = {8'h50, off};
    bus.rf_rp_zero = zero;
    do_reset();
    wait_fetch(16'd10, 200, found, cycles);
    n_cmp++;
    if (!found) begin
      n_fail++; $display("FAIL %s_reach10: no fetch at 000a within 200 cycles", name);
    end
    step(2);
    n_cmp++;
    if (bus.rf_rp_rd !== 1'b1 || bus.rf_rp_addr !== 4'd0 || bus.rf_w_wr !== 1'b0) begin
      n_fail++; $display("FAIL %s_test: rprd=%b rp=%h wwr=%b want 1/0/0", name,
                         bus.rf_rp_rd, bus.rf_rp_addr, bus.rf_w_wr);
    end
    step(exp_lat - 2);
    n_cmp++;
    if (bus.i_rd !== 1'b1 || bus.i_addr !== exp_pc) begin
      n_fail++; $display("FAIL %s_target: i_rd=%b i_addr=%h want 1/%h", name, bus.i_rd, bus.i_addr, exp_pc);
    end
    bus.rf_rp_zero = 1'b0;
  endtask

  task automatic test_jmpz();
    run_jmpz(8'hFE, 1'b1, 16'd8,  4, "jmpz_back");
    run_jmpz(8'hFE, 1'b0, 16'd11, 3, "jmpz_not");
    run_jmpz(8'h00, 1'b1, 16'd10, 4, "jmpz_self");
    run_jmpz(8'h01, 1'b1, 16'd11, 4, "jmpz_next");
    $display("test_jmpz done: compared=%0d mismatched=%0d", n_cmp, n_fail);
  endtask

  task automatic test_pc_wrap();
    logic seen;
    fill_nop();
    imem[0] = 16'h50FF;
    bus.rf_rp_zero = 1'b1;
    do_reset();
    step(5);
    n_cmp++;
    if (bus.i_rd !== 1'b1 || bus.i_addr !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_reach: i_rd=%b i_addr=%h want 1/ffff", bus.i_rd, bus.i_addr);
    end
    bus.rf_rp_zero = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      seen = seen | bus.d_rd | bus.d_wr | bus.rf_w_wr;
      step();
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL wrap_nop_strobes: got %b want 0", seen);
    end
    n_cmp++;
    if (bus.i_rd !== 1'b1 || bus.i_addr !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_fetch0: i_rd=%b i_addr=%h want 1/0000", bus.i_rd, bus.i_addr);
    end
    $display("test_pc_wrap done: compared=%0d mismatched=%0d", n_cmp, n_fail);
  endtask

  task automatic test_halt();
    int bad;
    fill_nop();
    imem[0] = 16'hF000;
    do_reset();
    step(3);
    bad = 0;
`ifdef HALT_EN
    for (int i = 0; i < 20; i++) begin
      if (bus.halted !== 1'b1 || bus.i_rd !== 1'b0 || bus.i_addr !== 16'h0001 ||
          bus.rf_w_wr !== 1'b0 || bus.d_wr !== 1'b0) bad++;
      step();
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++; $display("FAIL halt_hold: %0d bad cycles of 20, want 0 (halted=%b i_rd=%b)",
                         bad, bus.halted, bus.i_rd);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_reset: halted=%b want 0", bus.halted);
    end
    step();
    reset = 1'b0;
`else
    n_cmp++;
    if (bus.i_rd !== 1'b1 || bus.i_addr !== 16'h0001) begin
      n_fail++; $display("FAIL halt_as_nop: i_rd=%b i_addr=%h want 1/0001", bus.i_rd, bus.i_addr);
    end
    for (int i = 0; i < 20; i++) begin
      if (bus.halted !== 1'b0) bad++;
      step();
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++; $display("FAIL halted_tied: %0d cycles with halted=1, want 0", bad);
    end
`endif
    $display("test_halt done: compared=%0d mismatched=%0d", n_cmp, n_fail);
  endtask

  initial begin
    bus.rf_rp_zero = 1'b0;
    fill_nop();
    #1;
    n_cmp++;
    if (all_out() !== 55'd0) begin
      n_fail++; $display("FAIL reset_state: got %h want 0", all_out());
    end
    test_reset();
    test_loadc_sub();
    test_load_store();
    test_jmpz();
    test_pc_wrap();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
